// File: rtl/me_bus_access_pkg.sv
// me_bus_access_pkg: shared definitions for the MEM-stage bus access block.
// Holds the excCode values, access-width encodings, FSM state enum,
// the system bridge address map and a helper for device-window decode.
package me_bus_access_pkg;

  // excCode values forwarded to CP0
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Access width encodings carried by acc_wid
  localparam logic [2:0] WID_WORD = 3'd0;
  localparam logic [2:0] WID_HALF = 3'd1;
  localparam logic [2:0] WID_BYTE = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Address map: data memory is [0, DM_LIMIT]; each timer owns a
  // 12-byte window whose offset 8 is the read-only count register.
  localparam logic [31:0] DM_LIMIT      = 32'h0000_2FFF;
  localparam logic [31:0] DEV0_BASE     = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE     = 32'h0000_7F10;
  localparam logic [31:0] DEV_SPAN      = 32'd12;
  localparam logic [31:0] DEV_COUNT_OFF = 32'd8;

  // BUSY cycles allowed before a bus error (timeout build only)
  localparam int unsigned TIMEOUT = 15;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base);
    return (addr >= base) && (addr < base + DEV_SPAN);
  endfunction

endpackage

// File: rtl/me_bus_access_load_ext.sv
// load_ext: combinational load-data extraction and extension.
// Ports:
//   word_i  - full 32-bit word read from the bus
//   off_i   - byte offset of the access within the word
//   wid_i   - access width (WID_WORD / WID_HALF / WID_BYTE)
//   sign_i  - 1 = sign-extend, 0 = zero-extend
//   data_o  - right-aligned, extended result (0 for illegal widths)
module load_ext
  import me_bus_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  wid_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (off_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    case (wid_i)
      WID_WORD: data_o = word_i;
      WID_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
      WID_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/me_bus_access.sv
// me_bus_access: MEM-stage data access over the system bridge bus.
// Checks legality/alignment of the EX/MEM access, runs one req/ack bus
// transaction while stalling the pipeline, and returns extracted load data
// or an excCode for CP0.
// Optional feature: define ME_BUS_TIMEOUT_EN to raise DBE (excCode 7) when
// no bus_ack arrives within TIMEOUT BUSY cycles.
// Ports:
//   clk, reset (async, active-low), flush (abort current access)
//   acc_ld/acc_st/acc_addr/acc_wdata/acc_wid/acc_sign/exc_in - MEM access
//   stall, rdata, done, exc_out                              - to pipeline
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata, bus_ack/bus_rdata - bus
module me_bus_access
  import me_bus_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        acc_ld,
  input  logic        acc_st,
  input  logic [31:0] acc_addr,
  input  logic [31:0] acc_wdata,
  input  logic [2:0]  acc_wid,
  input  logic        acc_sign,
  input  logic [4:0]  exc_in,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic [4:0]  exc_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  off_q, off_d;
`ifdef ME_BUS_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);
  logic [3:0]  cnt_q, cnt_d;
`endif

  logic        acc, wid_ok, aligned, in_dm, in_dev0, in_dev1, in_dev;
  logic        ro_hit, legal, start, reject;
  logic [4:0]  adr_exc;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_data;

  // Extraction uses the offset captured at request time, so the result does
  // not depend on acc_addr staying stable through the ack edge.
  load_ext u_load_ext (
    .word_i (bus_rdata),
    .off_i  (off_q),
    .wid_i  (acc_wid),
    .sign_i (acc_sign),
    .data_o (ld_data)
  );

  // Access qualification, legality check and byte-lane steering
  always_comb begin
    acc     = (acc_ld | acc_st) && (exc_in == EXC_NONE);
    wid_ok  = acc_wid inside {WID_WORD, WID_HALF, WID_BYTE};
    aligned = !((acc_wid == WID_WORD && acc_addr[1:0] != 2'd0) ||
                (acc_wid == WID_HALF && acc_addr[0]));
    in_dm   = acc_addr <= DM_LIMIT;
    in_dev0 = in_window(acc_addr, DEV0_BASE);
    in_dev1 = in_window(acc_addr, DEV1_BASE);
    in_dev  = in_dev0 | in_dev1;
    // Timer count registers are read-only
    ro_hit  = acc_st && ((acc_addr == DEV0_BASE + DEV_COUNT_OFF) ||
                         (acc_addr == DEV1_BASE + DEV_COUNT_OFF));
    legal   = wid_ok && aligned && (in_dm || in_dev) &&
              !(in_dev && acc_wid != WID_WORD) && !ro_hit;
    adr_exc = acc_st ? EXC_ADES : EXC_ADEL;

    // done_q in IDLE marks a timeout completion cycle: the same instruction
    // is still presented, so no new access may start from it.
    start  = (state_q == ST_IDLE) && !done_q && acc && legal && !flush;
    reject = (state_q == ST_IDLE) && !done_q && acc && !legal;

    case (acc_wid)
      WID_BYTE: begin
        be_new    = 4'b0001 << acc_addr[1:0];
        wdata_new = {4{acc_wdata[7:0]}};
      end
      WID_HALF: begin
        be_new    = 4'b0011 << acc_addr[1:0];
        wdata_new = {2{acc_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = acc_wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      exc_q       <= EXC_NONE;
      off_q       <= '0;
`ifdef ME_BUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      off_q       <= off_d;
`ifdef ME_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state and datapath register inputs
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    off_d       = off_q;
    done_d      = 1'b0;
    exc_d       = EXC_NONE;
`ifdef ME_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = acc_st;
          bus_addr_d  = {acc_addr[31:2], 2'b00};
          bus_be_d    = be_new;
          bus_wdata_d = wdata_new;
          off_d       = acc_addr[1:0];
`ifdef ME_BUS_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          rdata_d   = ld_data;
          done_d    = 1'b1;
        end
`ifdef ME_BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          rdata_d   = '0;
          done_d    = 1'b1;
          exc_d     = EXC_DBE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything; a late ack then meets IDLE and is ignored.
    if (flush) begin
      state_d   = ST_IDLE;
      bus_req_d = 1'b0;
      done_d    = 1'b0;
      exc_d     = EXC_NONE;
    end
  end

  // Outputs
  always_comb begin
    stall     = start || (!flush && state_q == ST_BUSY);
    done      = !flush && (done_q || reject);
    rdata     = rdata_q;
    bus_req   = bus_req_q;
    bus_we    = bus_we_q;
    bus_addr  = bus_addr_q;
    bus_be    = bus_be_q;
    bus_wdata = bus_wdata_q;
    if (done_q)
      exc_out = exc_q;
    else if (reject)
      exc_out = adr_exc;
    else if (state_q == ST_IDLE)
      exc_out = exc_in;
    else
      exc_out = EXC_NONE;
  end

endmodule

// File: tb/tb_me_bus_access.sv
module tb_me_bus_access;

  logic        clk = 1'b0;
  logic        reset, flush, acc_ld, acc_st, acc_sign, bus_ack;
  logic [31:0] acc_addr, acc_wdata, bus_rdata;
  logic [2:0]  acc_wid;
  logic [4:0]  exc_in;
  logic        stall, done, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [4:0]  exc_out;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  me_bus_access dut (
    .clk(clk), .reset(reset), .flush(flush),
    .acc_ld(acc_ld), .acc_st(acc_st), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_wid(acc_wid), .acc_sign(acc_sign),
    .exc_in(exc_in), .stall(stall), .rdata(rdata), .done(done),
    .exc_out(exc_out), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    acc_ld = 0; acc_st = 0; acc_addr = 0; acc_wdata = 0;
    acc_wid = 0; acc_sign = 0; exc_in = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] wid, input logic sgn);
    acc_ld = ld; acc_st = st; acc_addr = addr; acc_wdata = wd;
    acc_wid = wid; acc_sign = sgn; exc_in = 0;
  endtask

  // kind: 0 = legal bus access, 1 = rejected by legality check, 2 = not qualified
  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wid;
    logic        sgn;
    logic [4:0]  exc_in;
    logic [31:0] rd;
    int          kind;
    logic [4:0]  e_exc;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 5'd0, 32'hDEADBEEF, 0, 5'd0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'h103,  32'h000000A5, 3'd2, 1'b0, 5'd0, 32'h0,        0, 5'd0, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h102,  32'h0,        3'd1, 1'b1, 5'd0, 32'h80011234, 0, 5'd0, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[3]  = '{1'b1, 1'b0, 32'h102,  32'h0,        3'd1, 1'b0, 5'd0, 32'h80011234, 0, 5'd0, 4'hC, 32'h0,        32'h00008001};
    vecs[4]  = '{1'b1, 1'b0, 32'h101,  32'h0,        3'd2, 1'b1, 5'd0, 32'h12348056, 0, 5'd0, 4'h2, 32'h0,        32'hFFFFFF80};
    vecs[5]  = '{1'b0, 1'b1, 32'h2FFE, 32'h1234ABCD, 3'd1, 1'b0, 5'd0, 32'h0,        0, 5'd0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h7F18, 32'h0,        3'd0, 1'b0, 5'd0, 32'h00000055, 0, 5'd0, 4'hF, 32'h0,        32'h00000055};
    vecs[7]  = '{1'b0, 1'b1, 32'h7F04, 32'h11223344, 3'd0, 1'b0, 5'd0, 32'h0,        0, 5'd0, 4'hF, 32'h11223344, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h2FFF, 32'h0,        3'd2, 1'b0, 5'd0, 32'hAB000000, 0, 5'd0, 4'h8, 32'h0,        32'h000000AB};
    vecs[9]  = '{1'b1, 1'b0, 32'h101,  32'h0,        3'd0, 1'b0, 5'd0, 32'h0,        1, 5'd4, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h7F08, 32'h1,        3'd0, 1'b0, 5'd0, 32'h0,        1, 5'd5, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h7F00, 32'h1,        3'd1, 1'b0, 5'd0, 32'h0,        1, 5'd5, 4'h0, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h3000, 32'h0,        3'd0, 1'b0, 5'd0, 32'h0,        1, 5'd4, 4'h0, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h7F0C, 32'h0,        3'd0, 1'b0, 5'd0, 32'h0,        1, 5'd4, 4'h0, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h10,   32'h0,        3'd3, 1'b0, 5'd0, 32'h0,        1, 5'd4, 4'h0, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h7F18, 32'h1,        3'd0, 1'b0, 5'd0, 32'h0,        1, 5'd5, 4'h0, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 5'd3, 32'h0,        2, 5'd3, 4'h0, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 1'b0, 32'h7F10, 32'h0,        3'd1, 1'b0, 5'd0, 32'h0,        1, 5'd4, 4'h0, 32'h0,        32'h0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; flush = 0;
    idle_inputs();
    #12;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_exc", exc_out, 0);
    chk("rst_stall", stall, 0);
    $display("reset checked");
    @(negedge clk); reset = 1;

    // Table-driven single accesses
    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      acc_ld = v.ld; acc_st = v.st; acc_addr = v.addr; acc_wdata = v.wdata;
      acc_wid = v.wid; acc_sign = v.sgn; exc_in = v.exc_in;
      bus_ack = 0; bus_rdata = 0;
      #1;
      if (v.kind == 0) begin
        chk("idle_stall", stall, 1);
        chk("idle_done", done, 0);
        @(negedge clk);
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, v.st);
        chk("busy_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("busy_be", bus_be, v.e_be);
        chk("busy_wdata", bus_wdata, v.e_wdata);
        chk("busy_stall", stall, 1);
        bus_ack = 1; bus_rdata = v.rd;
        @(negedge clk);
        bus_ack = 0;
        chk("done_done", done, 1);
        chk("done_stall", stall, 0);
        chk("done_exc", exc_out, 0);
        chk("done_req", bus_req, 0);
        if (v.ld) chk("done_rdata", rdata, v.e_rdata);
      end else if (v.kind == 1) begin
        chk("rej_done", done, 1);
        chk("rej_exc", exc_out, v.e_exc);
        chk("rej_stall", stall, 0);
        @(negedge clk);
        chk("rej_req", bus_req, 0);
      end else begin
        chk("pass_done", done, 0);
        chk("pass_exc", exc_out, v.e_exc);
        chk("pass_stall", stall, 0);
        @(negedge clk);
        chk("pass_req", bus_req, 0);
      end
      $display("vec %0d addr=%h wid=%0d kind=%0d rdata=%h exc=%0d", i, v.addr, v.wid, v.kind, rdata, exc_out);
      idle_inputs();
    end

    // Flush in the second BUSY cycle, late ack afterwards
    @(negedge clk);
    drive(1, 0, 32'h200, 0, 3'd0, 0);
    @(negedge clk);                         // BUSY cycle 1
    chk("fl_req_busy", bus_req, 1);
    @(negedge clk);                         // BUSY cycle 2
    flush = 1;
    #1;
    chk("fl_done_during", done, 0);
    @(negedge clk);
    chk("fl_req_after", bus_req, 0);
    flush = 0;
    idle_inputs();
    bus_ack = 1; bus_rdata = 32'h12345678;
    #1;
    chk("fl_late_done", done, 0);
    chk("fl_late_stall", stall, 0);
    @(negedge clk);
    bus_ack = 0;
    chk("fl_post_done", done, 0);
    chk("fl_post_req", bus_req, 0);
    $display("flush sequence: bus_req=%0d done=%0d", bus_req, done);

    // Long wait for ack
    @(negedge clk);
    drive(1, 0, 32'h300, 0, 3'd0, 0);
    @(negedge clk);                         // BUSY cycle 1
`ifdef ME_BUS_TIMEOUT_EN
    for (int k = 0; k < 14; k++) @(negedge clk);
    chk("to_stall_c15", stall, 1);
    chk("to_done_c15", done, 0);
    @(negedge clk);
    chk("to_done", done, 1);
    chk("to_exc", exc_out, 5'd7);
    chk("to_rdata", rdata, 0);
    chk("to_req", bus_req, 0);
    chk("to_stall", stall, 0);
    $display("timeout: exc=%0d done=%0d", exc_out, done);
`else
    for (int k = 0; k < 20; k++) begin
      chk("wait_stall", stall, 1);
      chk("wait_done", done, 0);
      @(negedge clk);
    end
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 0;
    chk("wait_done_final", done, 1);
    chk("wait_rdata", rdata, 32'hCAFEF00D);
    chk("wait_exc", exc_out, 0);
    $display("long wait: rdata=%h done=%0d", rdata, done);
`endif
    idle_inputs();

    // Reset in the middle of BUSY
    @(negedge clk);
    drive(1, 0, 32'h400, 0, 3'd0, 0);
    @(negedge clk);
    chk("mr_req_busy", bus_req, 1);
    reset = 0;
    #1;
    chk("mr_req", bus_req, 0);
    chk("mr_addr", bus_addr, 0);
    idle_inputs();
    #1;
    chk("mr_stall", stall, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mr_idle_req", bus_req, 0);
    chk("mr_idle_done", done, 0);
    $display("mid-busy reset: bus_req=%0d stall=%0d", bus_req, stall);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
